// File: rtl/dmem_banked.sv
// Banked data memory with valid/ready request/response handshake. Read data arrives
// the cycle after accept; a stalled response is frozen in a hold register and new requests wait.

module la_spram #(
  parameter int DW = 32,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          ce,
  input  logic          we,
  input  logic [DW-1:0] wmask,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);
  logic [DW-1:0] ram [2**AW];

  always_ff @(posedge clk) begin
    if (ce) begin
      if (we) ram[addr] <= (ram[addr] & ~wmask) | (din & wmask);
      else    dout      <= ram[addr];
    end
  end
endmodule

module dmem_banked #(
  parameter int DW         = 32,
  parameter int AW         = 8,
  parameter int NBANKS     = 4,
  parameter int INTERLEAVE = 0,
  parameter int ADDRW      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [ADDRW-1:0] req_addr,
  input  logic [DW-1:0]    req_wdata,
  input  logic [DW/8-1:0]  req_be,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [DW-1:0]    rsp_rdata,
  output logic             rsp_err
);
  localparam int NB  = DW / 8;
  localparam int OB  = $clog2(NB);
  localparam int BW  = (NBANKS > 1) ? $clog2(NBANKS) : 0;
  localparam int BWS = (BW > 0) ? BW : 1;
  localparam int TOP = OB + AW + BW;

  typedef enum logic [1:0] {IDLE, FRESH, HELD} state_t;

  state_t          state;
  logic            accept;
  logic            in_range;
  logic [AW-1:0]   row;
  logic [BWS-1:0]  bank;
  logic [DW-1:0]   wmask;
  logic [NBANKS-1:0] bank_ce;
  logic [DW-1:0]   dout [NBANKS];
  logic [DW-1:0]   dout_sel;
  logic [DW-1:0]   hold;
  logic            r_we;
  logic            r_err;
  logic [BWS-1:0]  r_bank;

  assign in_range  = (req_addr >> TOP) == '0;
  assign rsp_valid = !reset && (state != IDLE);
  assign req_ready = !reset && (!rsp_valid || rsp_ready);
  assign accept    = req_valid && req_ready;
  assign rsp_err   = rsp_valid && r_err;
  assign dout_sel  = dout[r_bank];

  // Bank select: contiguous uses the bits above the row, interleaved the bits below it.
  if (BW == 0) begin : g_single
    assign bank = '0;
    assign row  = req_addr[OB +: AW];
  end else if (INTERLEAVE == 0) begin : g_contig
    assign bank = req_addr[OB+AW +: BW];
    assign row  = req_addr[OB +: AW];
  end else begin : g_ilv
    assign bank = req_addr[OB +: BW];
    assign row  = req_addr[OB+BW +: AW];
  end

  always_comb begin
    wmask = '0;
    for (int k = 0; k < NB; k++) wmask[8*k +: 8] = {8{req_be[k]}};
  end

  always_comb begin
    bank_ce = '0;
    if (accept && in_range) bank_ce[bank] = 1'b1;
  end

  for (genvar b = 0; b < NBANKS; b++) begin : g_bank
    la_spram #(.DW(DW), .AW(AW)) u_ram (
      .clk   (clk),
      .ce    (bank_ce[b]),
      .we    (req_we),
      .wmask (wmask),
      .addr  (row),
      .din   (req_wdata),
      .dout  (dout[b])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      hold   <= '0;
      r_we   <= 1'b0;
      r_err  <= 1'b0;
      r_bank <= '0;
    end else begin
      if (state == FRESH && !rsp_ready) hold <= dout_sel;
      if (accept) begin
        r_we   <= req_we;
        r_err  <= !in_range;
        r_bank <= bank;
      end
      case (state)
        IDLE:    if (accept) state <= FRESH;
        FRESH,
        HELD:    if (rsp_ready) state <= accept ? FRESH : IDLE;
                 else           state <= HELD;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    rsp_rdata = '0;
    if (rsp_valid && !r_we && !r_err) rsp_rdata = (state == HELD) ? hold : dout_sel;
  end
endmodule

// File: tb/tb_dmem_banked.sv
// Directed bench for dmem_banked: contiguous and interleaved instances share one stimulus stream.
module tb_dmem_banked;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic        req_ready_il, rsp_valid_il, rsp_err_il;
  logic [31:0] rsp_rdata_il;
  int          chk_cnt = 0;
  int          pass_cnt = 0;

  always #5 clk = ~clk;

  dmem_banked #(.INTERLEAVE(0)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  dmem_banked #(.INTERLEAVE(1)) dut_il (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready_il),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid_il), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata_il), .rsp_err(rsp_err_il)
  );

  task automatic drive(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
  endtask

  task automatic idle_req();
    req_valid = 1'b0; req_we = 1'b0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_req(); rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid got %b want 0", rsp_valid); else pass_cnt++;
    chk_cnt++; if (rsp_err !== 1'b0) $display("FAIL rst_err got %b want 0", rsp_err); else pass_cnt++;
    chk_cnt++; if (rsp_rdata !== 32'h0) $display("FAIL rst_rdata got %h want 0", rsp_rdata); else pass_cnt++;
    chk_cnt++; if (req_ready !== 1'b0) $display("FAIL rst_ready got %b want 0", req_ready); else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 1'b1) $display("FAIL post_rst_ready got %b want 1", req_ready); else pass_cnt++;
    step();
  endtask

  task automatic test_defaults();
    drive(1'b1, 32'h0000_0104, 32'hDEADBEEF, 4'hF);
    @(negedge clk);
    chk_cnt++; if (dut.bank_ce !== 4'b0001) $display("FAIL def_wr_ce got %b want 0001", dut.bank_ce); else pass_cnt++;
    step();
    chk_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL def_wr_rsp got v=%b d=%h want v=1 d=0", rsp_valid, rsp_rdata); else pass_cnt++;
    drive(1'b0, 32'h0000_0104, 32'h0, 4'h0);
    step(); idle_req();
    chk_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF || rsp_err !== 1'b0)
      $display("FAIL def_rd got v=%b d=%h e=%b want v=1 d=deadbeef e=0", rsp_valid, rsp_rdata, rsp_err); else pass_cnt++;
    step();
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL def_drain got %b want 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_byte_strobes();
    drive(1'b1, 32'h0000_0200, 32'h11223344, 4'hF); step();
    drive(1'b1, 32'h0000_0200, 32'hAABBCCDD, 4'b1010); step();
    drive(1'b0, 32'h0000_0200, 32'h0, 4'h0); step(); idle_req();
    chk_cnt++; if (rsp_rdata !== 32'hAA22CC44) $display("FAIL be_merge got %h want aa22cc44", rsp_rdata); else pass_cnt++;
    drive(1'b1, 32'h0000_0200, 32'h0, 4'h0);
    @(negedge clk);
    chk_cnt++; if (dut.bank_ce !== 4'b0001) $display("FAIL be_zero_ce got %b want 0001", dut.bank_ce); else pass_cnt++;
    step();
    drive(1'b0, 32'h0000_0200, 32'h0, 4'h0); step(); idle_req();
    chk_cnt++; if (rsp_rdata !== 32'hAA22CC44) $display("FAIL be_zero_rd got %h want aa22cc44", rsp_rdata); else pass_cnt++;
    step();
  endtask

  task automatic test_banking();
    logic [3:0] exp_ce;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i) << 10, 32'hB000_0000 | 32'(i), 4'hF);
      exp_ce = 4'(1 << i);
      @(negedge clk);
      chk_cnt++; if (dut.bank_ce !== exp_ce) $display("FAIL bank_contig_ce%0d got %b want %b", i, dut.bank_ce, exp_ce); else pass_cnt++;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'(i) << 10, 32'h0, 4'h0); step();
      chk_cnt++; if (rsp_rdata !== (32'hB000_0000 | 32'(i)))
        $display("FAIL bank_contig_rd%0d got %h want %h", i, rsp_rdata, 32'hB000_0000 | 32'(i)); else pass_cnt++;
    end
    idle_req(); step();
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i) << 2, 32'hC000_0000 | 32'(i), 4'hF);
      exp_ce = 4'(1 << i);
      @(negedge clk);
      chk_cnt++; if (dut_il.bank_ce !== exp_ce) $display("FAIL bank_ilv_ce%0d got %b want %b", i, dut_il.bank_ce, exp_ce); else pass_cnt++;
      step();
    end
    for (int i = 0; i < 4; i++) begin
      drive(1'b0, 32'(i) << 2, 32'h0, 4'h0); step();
      chk_cnt++; if (rsp_rdata_il !== (32'hC000_0000 | 32'(i)))
        $display("FAIL bank_ilv_rd%0d got %h want %h", i, rsp_rdata_il, 32'hC000_0000 | 32'(i)); else pass_cnt++;
    end
    idle_req(); step();
  endtask

  task automatic test_back_pressure();
    drive(1'b0, 32'h0000_0104, 32'h0, 4'h0); step();
    drive(1'b0, 32'h0000_0200, 32'h0, 4'h0);
    rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
        $display("FAIL bp_hold%0d got v=%b d=%h want v=1 d=deadbeef", c, rsp_valid, rsp_rdata); else pass_cnt++;
      chk_cnt++; if (req_ready !== 1'b0) $display("FAIL bp_ready%0d got %b want 0", c, req_ready); else pass_cnt++;
      chk_cnt++; if (dut.bank_ce !== 4'b0000) $display("FAIL bp_ce%0d got %b want 0000", c, dut.bank_ce); else pass_cnt++;
      step();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    chk_cnt++; if (req_ready !== 1'b1 || dut.bank_ce !== 4'b0001)
      $display("FAIL bp_release got rdy=%b ce=%b want rdy=1 ce=0001", req_ready, dut.bank_ce); else pass_cnt++;
    chk_cnt++; if (rsp_rdata !== 32'hDEADBEEF) $display("FAIL bp_release_a got %h want deadbeef", rsp_rdata); else pass_cnt++;
    step(); idle_req();
    chk_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hAA22CC44)
      $display("FAIL bp_b got v=%b d=%h want v=1 d=aa22cc44", rsp_valid, rsp_rdata); else pass_cnt++;
    step();
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL bp_drain got %b want 0", rsp_valid); else pass_cnt++;
  endtask

  task automatic test_error();
    drive(1'b0, 32'h0000_1000, 32'h0, 4'h0);
    @(negedge clk);
    chk_cnt++; if (dut.bank_ce !== 4'b0000) $display("FAIL err_ce got %b want 0000", dut.bank_ce); else pass_cnt++;
    step();
    drive(1'b0, 32'h0000_0104, 32'h0, 4'h0);
    chk_cnt++; if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL err_rsp got v=%b e=%b d=%h want v=1 e=1 d=0", rsp_valid, rsp_err, rsp_rdata); else pass_cnt++;
    step();
    drive(1'b0, 32'h8000_0104, 32'h0, 4'h0);
    chk_cnt++; if (rsp_err !== 1'b0 || rsp_rdata !== 32'hDEADBEEF)
      $display("FAIL err_follow got e=%b d=%h want e=0 d=deadbeef", rsp_err, rsp_rdata); else pass_cnt++;
    step(); idle_req();
    chk_cnt++; if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0)
      $display("FAIL err_high got e=%b d=%h want e=1 d=0", rsp_err, rsp_rdata); else pass_cnt++;
    step();
  endtask

  task automatic test_reset_held();
    drive(1'b0, 32'h0000_0200, 32'h0, 4'h0); step(); idle_req();
    rsp_ready = 1'b0;
    step(); step();
    reset = 1'b1;
    drive(1'b1, 32'h0000_0104, 32'h0, 4'hF);
    @(negedge clk);
    chk_cnt++; if (req_ready !== 1'b0 || dut.bank_ce !== 4'b0000 || rsp_valid !== 1'b0)
      $display("FAIL rh_during got rdy=%b ce=%b v=%b want 0 0000 0", req_ready, dut.bank_ce, rsp_valid); else pass_cnt++;
    step();
    reset = 1'b0; idle_req(); rsp_ready = 1'b1;
    chk_cnt++; if (rsp_valid !== 1'b0) $display("FAIL rh_valid got %b want 0", rsp_valid); else pass_cnt++;
    drive(1'b0, 32'h0000_0104, 32'h0, 4'h0); step(); idle_req();
    chk_cnt++; if (rsp_valid !== 1'b1 || rsp_rdata !== 32'hDEADBEEF)
      $display("FAIL rh_persist got v=%b d=%h want v=1 d=deadbeef", rsp_valid, rsp_rdata); else pass_cnt++;
    step();
  endtask

  initial begin
    test_reset();
    test_defaults();
    test_byte_strobes();
    test_banking();
    test_back_pressure();
    test_error();
    test_reset_held();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
